// File: rtl/wave_read_arbiter.sv
// wave_read_arbiter
//   Time-multiplexes one wave-buffer BRAM read port between NUM_OSCILLATORS
//   oscillator lanes and two auxiliary requesters (viz, debug). Each round
//   issues one read per oscillator slot. It then adds one optional aux slot
//   when an aux request is pending. A {valid, id} tag follows every issue
//   through a BRAM_LATENCY-deep pipeline and steers the returning word to
//   its owner. At a round boundary the arbiter parks in HOLD while the
//   buffer is being reloaded.
//
// Ports
//   clk_in          system clock (100 MHz passthrough)
//   rst_in          asynchronous, active-high reset
//   wave_width_in   number of valid samples; indices at or above it read 0
//   loader_busy_in  wave buffer reload in progress
//   osc_index_in    per-oscillator sample index, oscillator 0 in the LSBs
//   osc_data_out    per-oscillator held sample
//   osc_valid_out   pulse when the matching osc_data_out slice updates
//   aux_req_in      aux requests, bit 0 = viz, bit 1 = debug
//   aux_index_in    aux indices, viz in the LSBs
//   aux_grant_out   pulse in the cycle an aux read is issued
//   aux_data_out    last aux sample; aux_valid_out names its owner
//   bram_en_out     BRAM read enable
//   bram_addr_out   BRAM read address
//   bram_data_in    BRAM read data, BRAM_LATENCY cycles after the address

// Per-requester return register. The slice shows the BRAM word in the
// cycle its tag arrives and holds that word until the next arrival.
module wave_read_lane #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    hit_in,
    input  logic [SAMPLE_WIDTH-1:0] data_in,
    output logic [SAMPLE_WIDTH-1:0] data_out,
    output logic                    valid_out
);
    logic [SAMPLE_WIDTH-1:0] hold_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in)      hold_q <= '0;
        else if (hit_in) hold_q <= data_in;
    end

    // Bypass the register so that data and valid line up exactly
    // BRAM_LATENCY cycles after the address.
    assign data_out  = hit_in ? data_in : hold_q;
    assign valid_out = hit_in;
endmodule

module wave_read_arbiter #(
    parameter int NUM_OSCILLATORS = 4,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int WW_WIDTH        = 15,
    parameter int BRAM_LATENCY    = 2
) (
    input  logic                                  clk_in,
    input  logic                                  rst_in,
    input  logic [WW_WIDTH-1:0]                   wave_width_in,
    input  logic                                  loader_busy_in,
    input  logic [NUM_OSCILLATORS*WW_WIDTH-1:0]   osc_index_in,
    output logic [NUM_OSCILLATORS*SAMPLE_WIDTH-1:0] osc_data_out,
    output logic [NUM_OSCILLATORS-1:0]            osc_valid_out,
    input  logic [1:0]                            aux_req_in,
    input  logic [2*WW_WIDTH-1:0]                 aux_index_in,
    output logic [1:0]                            aux_grant_out,
    output logic [SAMPLE_WIDTH-1:0]               aux_data_out,
    output logic [1:0]                            aux_valid_out,
    output logic                                  bram_en_out,
    output logic [WW_WIDTH-1:0]                   bram_addr_out,
    input  logic [SAMPLE_WIDTH-1:0]               bram_data_in
);
    localparam int NUM_REQ = NUM_OSCILLATORS + 2;
    localparam int ID_W    = $clog2(NUM_REQ);
    localparam int SLOT_W  = (NUM_OSCILLATORS > 1) ? $clog2(NUM_OSCILLATORS) : 1;
    localparam int STAGES  = BRAM_LATENCY;

    typedef enum logic [1:0] {ISSUE_OSC, ISSUE_AUX, HOLD} state_t;

    // One read issue, decided combinationally and registered onto the port.
    typedef struct packed {
        logic                en;
        logic [WW_WIDTH-1:0] addr;
        logic [ID_W-1:0]     id;
        logic [1:0]          grant;
    } issue_t;

    state_t              state_q, state_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                ptr_q, ptr_d;     // 0 = viz has priority, 1 = debug
    logic                aux_pick;
    issue_t              iss;

    logic [NUM_OSCILLATORS-1:0][WW_WIDTH-1:0] osc_idx;
    logic [1:0][WW_WIDTH-1:0]                 aux_idx;

    // vld_pipe[0]/id_pipe[0] ride with the registered address. Stage STAGES
    // lines up with the BRAM word for that address.
    logic [STAGES:0]            vld_pipe;
    logic [STAGES:0][ID_W-1:0]  id_pipe;
    logic [WW_WIDTH-1:0]        addr_q;
    logic [1:0]                 grant_q;

    assign osc_idx = osc_index_in;
    assign aux_idx = aux_index_in;

    function automatic logic [WW_WIDTH-1:0] clamp_addr(
        input logic [WW_WIDTH-1:0] idx,
        input logic [WW_WIDTH-1:0] width
    );
        return (idx < width) ? idx : '0;
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= ISSUE_OSC;
            slot_q  <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        slot_d   = slot_q;
        ptr_d    = ptr_q;
        iss      = '0;
        aux_pick = 1'b0;
        case (state_q)
            // HOLD always sits at slot 0. It therefore shares the round-start
            // busy check, and it issues slot 0 as soon as the loader releases.
            ISSUE_OSC, HOLD: begin
                if ((state_q == HOLD || slot_q == '0) && loader_busy_in) begin
                    state_d = HOLD;
                end else begin
                    iss.en   = 1'b1;
                    iss.addr = clamp_addr(osc_idx[slot_q], wave_width_in);
                    iss.id   = ID_W'(slot_q);
                    if (slot_q == SLOT_W'(NUM_OSCILLATORS - 1)) begin
                        slot_d  = '0;
                        state_d = (|aux_req_in) ? ISSUE_AUX : ISSUE_OSC;
                    end else begin
                        slot_d  = slot_q + 1'b1;
                        state_d = ISSUE_OSC;
                    end
                end
            end
            ISSUE_AUX: begin
                slot_d  = '0;
                state_d = ISSUE_OSC;
                // A request dropped after the round committed to an aux slot
                // costs one idle cycle.
                if (|aux_req_in) begin
                    aux_pick            = (&aux_req_in) ? ptr_q : aux_req_in[1];
                    iss.en              = 1'b1;
                    iss.addr            = clamp_addr(aux_idx[aux_pick], wave_width_in);
                    iss.id              = ID_W'(NUM_OSCILLATORS) + ID_W'(aux_pick);
                    iss.grant[aux_pick] = 1'b1;
                    ptr_d               = ~aux_pick;
                end
            end
            default: begin
                state_d = ISSUE_OSC;
                slot_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            addr_q   <= '0;
            grant_q  <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], iss.en};
            id_pipe  <= {id_pipe[STAGES-1:0], iss.id};
            addr_q   <= iss.addr;
            grant_q  <= iss.grant;
        end
    end

    assign bram_en_out   = vld_pipe[0];
    assign bram_addr_out = addr_q;
    assign aux_grant_out = grant_q;

    logic                       exit_vld;
    logic [ID_W-1:0]            exit_id;
    logic [NUM_OSCILLATORS-1:0] osc_hit;
    logic                       aux_hit;
    logic                       aux_lane_vld;
    logic [1:0]                 aux_owner;

    assign exit_vld = vld_pipe[STAGES];
    assign exit_id  = id_pipe[STAGES];

    genvar g;
    generate
        for (g = 0; g < NUM_OSCILLATORS; g++) begin : g_osc
            assign osc_hit[g] = exit_vld && (exit_id == ID_W'(g));
            wave_read_lane #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_lane (
                .clk_in    (clk_in),
                .rst_in    (rst_in),
                .hit_in    (osc_hit[g]),
                .data_in   (bram_data_in),
                .data_out  (osc_data_out[g*SAMPLE_WIDTH +: SAMPLE_WIDTH]),
                .valid_out (osc_valid_out[g])
            );
        end
    endgenerate

    // Both aux requesters share one data register; aux_valid_out tells
    // which of them owns the current word.
    assign aux_hit   = exit_vld && (exit_id >= ID_W'(NUM_OSCILLATORS));
    assign aux_owner = {exit_id == ID_W'(NUM_OSCILLATORS + 1),
                        exit_id == ID_W'(NUM_OSCILLATORS)};

    wave_read_lane #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_aux_lane (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .hit_in    (aux_hit),
        .data_in   (bram_data_in),
        .data_out  (aux_data_out),
        .valid_out (aux_lane_vld)
    );

    assign aux_valid_out = aux_owner & {2{aux_lane_vld}};
endmodule

// File: tb/tb_wave_read_arbiter.sv
module tb_wave_read_arbiter;
    localparam int N  = 4;
    localparam int SW = 16;
    localparam int WW = 15;
    localparam int L  = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [WW-1:0]     wave_width_in;
    logic              loader_busy_in;
    logic [N*WW-1:0]   osc_index_in;
    logic [N*SW-1:0]   osc_data_out;
    logic [N-1:0]      osc_valid_out;
    logic [1:0]        aux_req_in;
    logic [2*WW-1:0]   aux_index_in;
    logic [1:0]        aux_grant_out;
    logic [SW-1:0]     aux_data_out;
    logic [1:0]        aux_valid_out;
    logic              bram_en_out;
    logic [WW-1:0]     bram_addr_out;
    logic [SW-1:0]     bram_data_in;

    always #5 clk_in = ~clk_in;

    wave_read_arbiter #(.NUM_OSCILLATORS(N), .SAMPLE_WIDTH(SW),
                        .WW_WIDTH(WW), .BRAM_LATENCY(L)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .wave_width_in(wave_width_in),
        .loader_busy_in(loader_busy_in), .osc_index_in(osc_index_in),
        .osc_data_out(osc_data_out), .osc_valid_out(osc_valid_out),
        .aux_req_in(aux_req_in), .aux_index_in(aux_index_in),
        .aux_grant_out(aux_grant_out), .aux_data_out(aux_data_out),
        .aux_valid_out(aux_valid_out), .bram_en_out(bram_en_out),
        .bram_addr_out(bram_addr_out), .bram_data_in(bram_data_in)
    );

    // BRAM model: data = address, L cycles after the address is presented.
    logic [WW-1:0] bpipe [1:L];
    always @(posedge clk_in) begin
        bpipe[1] <= bram_addr_out;
        for (int j = 2; j <= L; j++) bpipe[j] <= bpipe[j-1];
    end
    assign bram_data_in = SW'(bpipe[L]);

    // Reference model: round position, aux priority and a delivery queue.
    typedef struct { int due; int id; int data; } dl_t;
    dl_t q[$];
    int cyc = 0, pos = 0, ptr = 0;
    int tests = 0, fails = 0;
    logic          e_en;
    int            e_addr;
    logic [1:0]    e_grant, e_aval;
    logic [N-1:0]  e_oval;
    logic [N*SW-1:0] e_odata;
    logic [SW-1:0] e_adata;

    function automatic int clampi(int idx, int w);
        return (idx < w) ? idx : 0;
    endfunction

    task automatic model_reset();
        pos = 0; ptr = 0; q.delete();
        e_en = 0; e_addr = 0; e_grant = 0; e_aval = 0; e_oval = 0;
        e_odata = '0; e_adata = '0;
    endtask

    task automatic model_edge();
        dl_t d;
        int a, g;
        e_en = 0; e_addr = 0; e_grant = 0; e_oval = 0; e_aval = 0;
        if (rst_in) begin model_reset(); return; end
        if (pos < N) begin
            if (!(pos == 0 && loader_busy_in)) begin
                a = clampi(int'(osc_index_in[pos*WW +: WW]), int'(wave_width_in));
                e_en = 1; e_addr = a;
                q.push_back('{cyc + L, pos, a});
                if (pos == N - 1) pos = (aux_req_in != 2'b00) ? N : 0;
                else pos++;
            end
        end else begin
            pos = 0;
            if (aux_req_in != 2'b00) begin
                g = (aux_req_in == 2'b11) ? ptr : (aux_req_in[1] ? 1 : 0);
                a = clampi(int'(aux_index_in[g*WW +: WW]), int'(wave_width_in));
                e_en = 1; e_addr = a; e_grant[g] = 1'b1;
                q.push_back('{cyc + L, N + g, a});
                ptr = 1 - g;
            end
        end
        while (q.size() != 0 && q[0].due == cyc) begin
            d = q.pop_front();
            if (d.id < N) begin
                e_oval[d.id] = 1'b1;
                e_odata[d.id*SW +: SW] = SW'(d.data);
            end else begin
                e_aval[d.id-N] = 1'b1;
                e_adata = SW'(d.data);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all(input string ph);
        chk({ph, ":bram_en"},   64'(bram_en_out),   64'(e_en));
        chk({ph, ":bram_addr"}, 64'(bram_addr_out), 64'(e_addr));
        chk({ph, ":grant"},     64'(aux_grant_out), 64'(e_grant));
        chk({ph, ":osc_valid"}, 64'(osc_valid_out), 64'(e_oval));
        chk({ph, ":osc_data"},  64'(osc_data_out),  64'(e_odata));
        chk({ph, ":aux_valid"}, 64'(aux_valid_out), 64'(e_aval));
        chk({ph, ":aux_data"},  64'(aux_data_out),  64'(e_adata));
    endtask

    task automatic step(input string ph);
        @(posedge clk_in);
        cyc++;
        model_edge();
        @(negedge clk_in);
        check_all(ph);
    endtask

    // Called at a negedge; reset rises mid-phase, away from any clock edge.
    task automatic async_reset(input int hold_edges);
        #2 rst_in = 1'b1;
        #1 model_reset();
        check_all("async_rst");
        repeat (hold_edges) step("in_rst");
        rst_in = 1'b0;
    endtask

    task automatic set_osc(input int i0, input int i1, input int i2, input int i3);
        osc_index_in = {WW'(i3), WW'(i2), WW'(i1), WW'(i0)};
    endtask

    initial begin
        int en_cnt, grant_cnt;
        logic [1:0]    first_g;
        logic [SW-1:0] v_viz, v_dbg;
        int ww_tab[5] = '{0, 16, 24, 32, 100};

        rst_in = 1'b1; wave_width_in = WW'(100); loader_busy_in = 1'b0;
        set_osc(10, 20, 30, 40); aux_req_in = 2'b00; aux_index_in = '0;
        #3 model_reset();
        check_all("reset");
        step("reset"); step("reset");
        rst_in = 1'b0;

        // Oscillator-only rounds.
        repeat (12) step("osc_only");
        chk("osc_slices", 64'(osc_data_out), 64'({16'd40, 16'd30, 16'd20, 16'd10}));

        // Both aux requesters pending: alternating viz/debug rounds.
        aux_index_in = {WW'(7), WW'(5)}; aux_req_in = 2'b11;
        first_g = 2'b00; v_viz = '0; v_dbg = '0; grant_cnt = 0;
        for (int i = 0; i < 15; i++) begin
            step("aux_both");
            if (aux_grant_out != 2'b00 && first_g == 2'b00) first_g = aux_grant_out;
            if (aux_valid_out == 2'b01) v_viz = aux_data_out;
            if (aux_valid_out == 2'b10) v_dbg = aux_data_out;
            if (aux_grant_out != 2'b00) grant_cnt++;
        end
        aux_req_in = 2'b00;
        repeat (6) step("aux_drain");
        chk("first_grant_viz", 64'(first_g), 64'(2'b01));
        chk("viz_data", 64'(v_viz), 64'(5));
        chk("dbg_data", 64'(v_dbg), 64'(7));
        chk("aux_grant_count", 64'(grant_cnt), 64'(3));

        // Index clamping against wave_width_in.
        wave_width_in = WW'(16); set_osc(16, 15, 20, 0);
        repeat (8) step("clamp16");
        wave_width_in = '0; set_osc(1, 2, 3, 4);
        for (int i = 0; i < 8; i++) begin
            step("ww0");
            chk("ww0_addr", 64'(bram_addr_out), 64'(0));
        end

        // Loader busy raised just after the slot 2 issue.
        wave_width_in = WW'(100); set_osc(10, 20, 30, 40);
        for (int i = 0; i < 8 && pos != 3; i++) step("sync");
        loader_busy_in = 1'b1; en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step("busy");
            if (bram_en_out) en_cnt++;
        end
        chk("busy_issue_count", 64'(en_cnt), 64'(1));
        loader_busy_in = 1'b0;
        step("release");
        chk("release_slot0_en", 64'(bram_en_out), 64'(1));
        chk("release_slot0_addr", 64'(bram_addr_out), 64'(10));
        repeat (6) step("after_busy");

        // Async reset one cycle after the slot 1 issue.
        for (int i = 0; i < 8 && pos != 0; i++) step("sync0");
        step("pre_rst"); step("pre_rst"); step("pre_rst");
        async_reset(2);
        step("post_rst");
        chk("post_rst_first_addr", 64'(bram_addr_out), 64'(10));
        repeat (5) step("post_rst");

        // Viz request withdrawn before its aux slot.
        for (int i = 0; i < 8 && pos != 1; i++) step("sync1");
        aux_index_in = {WW'(7), WW'(5)}; aux_req_in = 2'b01;
        step("viz_req");
        aux_req_in = 2'b00; grant_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            step("viz_drop");
            if (aux_grant_out != 2'b00) grant_cnt++;
        end
        chk("drop_no_grant", 64'(grant_cnt), 64'(0));

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) wave_width_in = WW'(ww_tab[$urandom_range(0, 4)]);
            for (int k = 0; k < N; k++) osc_index_in[k*WW +: WW] = WW'($urandom_range(0, 40));
            if ($urandom_range(0, 15) == 0) loader_busy_in = ~loader_busy_in;
            for (int b = 0; b < 2; b++) begin
                if ($urandom_range(0, 3) == 0) begin
                    aux_req_in[b] = ~aux_req_in[b];
                    if (aux_req_in[b]) aux_index_in[b*WW +: WW] = WW'($urandom_range(0, 40));
                end
            end
            step("rand");
            if (i == 300) async_reset(2);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
